id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection, directly upstream of forwarding unit.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/load_use_detect.sv | 15 +
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: decoded control bundle, bubble constant and ID/EX stage states.
package cpu_pkg;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 3;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stage_state_e;
endpackage

// File: rtl/load_use_detect.sv
// Pure comparator: a pending load's destination matches either operand register of a consumer.
module load_use_detect #(
  parameter int RW = 3
) (
  input  logic          ld_valid_i,
  input  logic [RW-1:0] ld_rd_i,
  input  logic          use_valid_i,
  input  logic [RW-1:0] use_rs_i,
  input  logic [RW-1:0] use_rd_i,
  output logic          hazard_o
);
  // r0 is hardwired zero, so a load into it never produces a dependency
  assign hazard_o = ld_valid_i && (ld_rd_i != '0) && use_valid_i &&
                    ((ld_rd_i == use_rs_i) || (ld_rd_i == use_rd_i));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, held-flush latch and saturating stall counter.
module id_ex_stage import cpu_pkg::*; #(
  parameter int DW       = DW_DEF,
  parameter int RW       = RW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rd,
  input  logic [DW-1:0]    id_rs_val,
  input  logic [DW-1:0]    id_rd_val,
  input  logic [DW-1:0]    id_imm,
  input  ctrl_t            id_ctrl,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rd,
  output logic [DW-1:0]    ex_rs_val,
  output logic [DW-1:0]    ex_rd_val,
  output logic [DW-1:0]    ex_imm,
  output ctrl_t            ex_ctrl,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic [CNT_W-1:0] stall_count
);
  localparam int BW = 3;

  logic             ex_valid_q, ex_valid_d;
  logic [RW-1:0]    ex_rs_q, ex_rs_d, ex_rd_q, ex_rd_d;
  logic [DW-1:0]    ex_rs_val_q, ex_rs_val_d, ex_rd_val_q, ex_rd_val_d, ex_imm_q, ex_imm_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  stage_state_e     state_q, state_d;
  logic [BW-1:0]    bub_cnt_q, bub_cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_use, hazard, eff_flush, stall_cycle, load_bubble;

  load_use_detect #(.RW(RW)) u_detect (
    .ld_valid_i (ex_valid_q && ex_ctrl_q.mem_read),
    .ld_rd_i    (ex_rd_q),
    .use_valid_i(id_valid),
    .use_rs_i   (id_rs),
    .use_rd_i   (id_rd),
    .hazard_o   (ld_use)
  );

  assign hazard      = (state_q == RUN) && ld_use;
  assign eff_flush   = flush || pend_flush_q;
  assign stall_cycle = !ex_hold && !eff_flush && (hazard || (state_q == STALL));
  assign pc_write_en   = !ex_hold && !stall_cycle;
  assign ifid_write_en = pc_write_en;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs_d      = ex_rs_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_val_d  = ex_rs_val_q;
    ex_rd_val_d  = ex_rd_val_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    state_d      = state_q;
    bub_cnt_d    = bub_cnt_q;
    pend_flush_d = pend_flush_q;
    load_bubble  = 1'b0;
    if (ex_hold) begin
      pend_flush_d = pend_flush_q || flush;
    end else if (eff_flush) begin
      load_bubble  = 1'b1;
      state_d      = RUN;
      bub_cnt_d    = '0;
      pend_flush_d = 1'b0;
    end else if (state_q == STALL) begin
      load_bubble = 1'b1;
      bub_cnt_d   = bub_cnt_q - 1'b1;
      if (bub_cnt_q == BW'(1)) state_d = RUN;
    end else if (hazard) begin
      load_bubble = 1'b1;
      bub_cnt_d   = BW'(LOAD_LAT - 1);
      state_d     = (LOAD_LAT == 1) ? RUN : STALL;
    end else if (id_valid) begin
      ex_valid_d  = 1'b1;
      ex_rs_d     = id_rs;
      ex_rd_d     = id_rd;
      ex_rs_val_d = id_rs_val;
      ex_rd_val_d = id_rd_val;
      ex_imm_d    = id_imm;
      ex_ctrl_d   = id_ctrl;
    end else begin
      load_bubble = 1'b1;
    end
    // bubbles carry zero registers so the forwarding unit never matches on them
    if (load_bubble) begin
      ex_valid_d  = 1'b0;
      ex_rs_d     = '0;
      ex_rd_d     = '0;
      ex_rs_val_d = '0;
      ex_rd_val_d = '0;
      ex_imm_d    = '0;
      ex_ctrl_d   = CTRL_BUBBLE;
    end
  end

  assign cnt_d = (stall_cycle && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_val_q  <= '0;
      ex_rd_val_q  <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= CTRL_BUBBLE;
      state_q      <= RUN;
      bub_cnt_q    <= '0;
      pend_flush_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_val_q  <= ex_rs_val_d;
      ex_rd_val_q  <= ex_rd_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      state_q      <= state_d;
      bub_cnt_q    <= bub_cnt_d;
      pend_flush_q <= pend_flush_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rs_val   = ex_rs_val_q;
  assign ex_rd_val   = ex_rd_val_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench: two stages (1- and 3-cycle load latency) checked against a remaining-bubble model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic       v;
    logic [2:0] rs, rd;
    logic [7:0] rsv, rdv, imm;
    ctrl_t      ctrl;
  } exrec_t;

  typedef struct {
    bit     chk_we;
    bit     we;
    exrec_t ex;
    int     cnt;
  } exp_t;

  localparam int CW = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 1'b0, flush = 1'b0, ex_hold = 1'b0;
  logic [2:0] id_rs = '0, id_rd = '0;
  logic [7:0] id_rs_val = '0, id_rd_val = '0, id_imm = '0;
  ctrl_t id_ctrl = '0;

  logic [1:0]          o_v, o_pcwe, o_ifwe;
  logic [1:0][2:0]     o_rs, o_rd;
  logic [1:0][7:0]     o_rsv, o_rdv, o_imm;
  ctrl_t               o_ctrl [2];
  logic [1:0][CW-1:0]  o_cnt;

  int checks = 0, errors = 0;

  exrec_t m_ex [2];
  int     m_left [2];
  bit     m_pend [2];
  int     m_cnt [2];
  int     lat [2] = '{1, 3};
  exp_t   q0 [$];
  exp_t   q1 [$];

  always #5 clk = ~clk;

  id_ex_stage #(.DW(8), .RW(3), .LOAD_LAT(1), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rd_val(id_rd_val), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .ex_hold(ex_hold), .ex_valid(o_v[0]), .ex_rs(o_rs[0]), .ex_rd(o_rd[0]),
    .ex_rs_val(o_rsv[0]), .ex_rd_val(o_rdv[0]), .ex_imm(o_imm[0]), .ex_ctrl(o_ctrl[0]),
    .pc_write_en(o_pcwe[0]), .ifid_write_en(o_ifwe[0]), .stall_count(o_cnt[0]));

  id_ex_stage #(.DW(8), .RW(3), .LOAD_LAT(3), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rd_val(id_rd_val), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .ex_hold(ex_hold), .ex_valid(o_v[1]), .ex_rs(o_rs[1]), .ex_rd(o_rd[1]),
    .ex_rs_val(o_rsv[1]), .ex_rd_val(o_rdv[1]), .ex_imm(o_imm[1]), .ex_ctrl(o_ctrl[1]),
    .pc_write_en(o_pcwe[1]), .ifid_write_en(o_ifwe[1]), .stall_count(o_cnt[1]));

  // m_left = bubbles still owed after the current one; stalled whenever a hazard fires or m_left>0
  task automatic model_step(int d);
    exp_t e;
    bit eff, haz, stall;
    eff   = flush || m_pend[d];
    haz   = (m_left[d] == 0) && m_ex[d].v && m_ex[d].ctrl.mem_read && (m_ex[d].rd != 3'd0) &&
            id_valid && ((m_ex[d].rd == id_rs) || (m_ex[d].rd == id_rd));
    stall = haz || (m_left[d] > 0);
    e.chk_we = !reset;
    e.we     = !ex_hold && (eff || !stall);
    if (reset) begin
      m_ex[d] = '0; m_left[d] = 0; m_pend[d] = 0; m_cnt[d] = 0;
    end else if (ex_hold) begin
      m_pend[d] = m_pend[d] || flush;
    end else if (eff) begin
      m_ex[d] = '0; m_left[d] = 0; m_pend[d] = 0;
    end else if (stall) begin
      m_ex[d]   = '0;
      m_left[d] = haz ? lat[d] - 1 : m_left[d] - 1;
      if (m_cnt[d] < (1 << CW) - 1) m_cnt[d]++;
    end else if (id_valid) begin
      m_ex[d] = {1'b1, id_rs, id_rd, id_rs_val, id_rd_val, id_imm, id_ctrl};
    end else begin
      m_ex[d] = '0;
    end
    e.ex  = m_ex[d];
    e.cnt = m_cnt[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drive(bit v, logic [2:0] rs, logic [2:0] rd, bit mr,
                       bit fl = 0, bit hd = 0, bit rst = 0);
    @(negedge clk); #1;
    reset     = rst;
    id_valid  = v;
    id_rs     = rs;
    id_rd     = rd;
    id_rs_val = 8'($urandom);
    id_rd_val = 8'($urandom);
    id_imm    = 8'($urandom);
    id_ctrl   = ctrl_t'($urandom);
    id_ctrl.mem_read = mr;
    flush     = fl;
    ex_hold   = hd;
    model_step(0);
    model_step(1);
  endtask

  task automatic check(int d, exp_t e, bit we_s, bit ifwe_s);
    exrec_t act;
    act = {o_v[d], o_rs[d], o_rd[d], o_rsv[d], o_rdv[d], o_imm[d], o_ctrl[d]};
    if (e.chk_we) begin
      checks += 2;
      if (we_s !== e.we) begin
        errors++;
        $display("FAIL pc_write_en dut%0d t=%0t got %b want %b", d, $time, we_s, e.we);
      end
      if (ifwe_s !== e.we) begin
        errors++;
        $display("FAIL ifid_write_en dut%0d t=%0t got %b want %b", d, $time, ifwe_s, e.we);
      end
    end
    checks += 2;
    if (act !== e.ex) begin
      errors++;
      $display("FAIL ex_regs dut%0d t=%0t got %h want %h", d, $time, act, e.ex);
    end
    if (int'(o_cnt[d]) !== e.cnt) begin
      errors++;
      $display("FAIL stall_count dut%0d t=%0t got %0d want %0d", d, $time, o_cnt[d], e.cnt);
    end
  endtask

  // monitor: comb enables just before the edge, registered outputs just after
  initial begin
    logic [1:0] we_s, ifwe_s;
    forever begin
      @(negedge clk); #4;
      we_s   = o_pcwe;
      ifwe_s = o_ifwe;
      @(posedge clk); #1;
      if (q0.size() > 0) check(0, q0.pop_front(), we_s[0], ifwe_s[0]);
      if (q1.size() > 0) check(1, q1.pop_front(), we_s[1], ifwe_s[1]);
    end
  end

  initial begin
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1);
    // reset arriving mid-stall
    drive(1, 3'd1, 3'd2, 1);
    drive(1, 3'd2, 3'd1, 0);
    drive(1, 3'd2, 3'd1, 0);
    drive(1, 3'd2, 3'd1, 0, 0, 0, 1);
    drive(0, 0, 0, 0);
    // lw r2 then add using r2, ID held until it issues
    drive(1, 3'd1, 3'd2, 1);
    repeat (4) drive(1, 3'd2, 3'd1, 0);
    drive(0, 0, 0, 0);
    // r0 load, non-matching regs, then second-source match
    drive(1, 3'd1, 3'd0, 1);
    drive(1, 3'd0, 3'd0, 0);
    drive(1, 3'd1, 3'd3, 1);
    drive(1, 3'd1, 3'd4, 0);
    drive(1, 3'd1, 3'd3, 1);
    repeat (4) drive(1, 3'd5, 3'd3, 0);
    // hazard coinciding with flush
    drive(1, 3'd1, 3'd2, 1);
    drive(1, 3'd2, 3'd1, 0, 1);
    drive(0, 0, 0, 0);
    // hold 3 cycles with a flush pulse in the middle
    drive(1, 3'd4, 3'd5, 0);
    drive(1, 3'd6, 3'd7, 0, 0, 1);
    drive(1, 3'd6, 3'd7, 0, 1, 1);
    drive(1, 3'd6, 3'd7, 0, 0, 1);
    drive(1, 3'd6, 3'd7, 0);
    drive(1, 3'd6, 3'd7, 0);
    // self-dependent loads to drive the counter into saturation
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 3'd1, 3'd1, 1);
    repeat (60) drive(1, 3'd1, 3'd1, 1);
    // randomized traffic over a small register set to make hazards common
    repeat (600) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0);
    end
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
